// File: rtl/dlx_mem_pkg.sv
// Shared types and default widths for the DLX memory-side arbiter.
// No configuration macros are used here; RAM_ARBITER_ROUND_ROBIN_EN is consumed by ram_arbiter.
package dlx_mem_pkg;

    localparam int DLX_ADDR_WIDTH = 32;
    localparam int DLX_DATA_WIDTH = 32;
    localparam int DLX_MAX_LOCK   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                      req;
        logic                      lock;
        logic                      we;
        logic [DLX_ADDR_WIDTH-1:0] addr;
        logic [DLX_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Two requester ports plus the single-ported RAM side of the arbiter.
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high in the same
// cycle (that cycle is the transfer); read data returns one cycle later qualified by rvalid.
interface ram_arbiter_if
    import dlx_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DLX_ADDR_WIDTH,
    parameter int DATA_WIDTH = DLX_DATA_WIDTH
);
    logic                  m0_req;
    logic                  m0_lock;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_rvalid;

    logic                  m1_req;
    logic                  m1_lock;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_rvalid;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ram_rdata_valid;

    // Arbiter side
    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rdata, m0_rvalid,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rdata, m1_rvalid,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata, ram_rdata_valid
    );

    // Requesters and RAM side
    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rdata, m0_rvalid,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata, ram_rdata_valid
    );

endinterface

// File: rtl/arb_pick2.sv
// Two-way winner selection: ptr_i names the preferred port on contention.
// Output is one-hot (or zero when nobody requests).
module arb_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~ptr_i | ~req_i[1]);
        gnt_o[1] = req_i[1] & ( ptr_i | ~req_i[0]);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM between the DLX data port (m0) and a second master (m1), with bus locking.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin contention; otherwise m0 has fixed priority.
module ram_arbiter
    import dlx_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DLX_ADDR_WIDTH,
    parameter int DATA_WIDTH = DLX_DATA_WIDTH,
    parameter int MAX_LOCK   = DLX_MAX_LOCK
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus,
    output arb_state_e    state_o
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e            state_q;
    logic [CNT_W-1:0]      lock_cnt_q;
    logic                  force_q;
    logic                  force_ptr_q;
    logic                  rpend_q;
    logic                  rtag_q;

    logic [1:0]            req;
    logic [1:0]            pick;
    logic [1:0]            gnt;
    logic                  pick_ptr;
    logic                  sel_lock;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [CNT_W-1:0]      cnt_next;

    assign req = {bus.m1_req, bus.m0_req};

    // After a forced release the non-owner is preferred for exactly one IDLE cycle.
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic rr_ptr_q;
    assign pick_ptr = force_q ? force_ptr_q : rr_ptr_q;
`else
    assign pick_ptr = force_q ? force_ptr_q : 1'b0;
`endif

    arb_pick2 u_pick (
        .req_i (req),
        .ptr_i (pick_ptr),
        .gnt_o (pick)
    );

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (state_q)
                IDLE:    gnt = pick;
                OWN0:    gnt = {1'b0, req[0]};
                OWN1:    gnt = {req[1], 1'b0};
                default: gnt = 2'b00;
            endcase
        end
        sel_lock  = gnt[1] ? bus.m1_lock  : bus.m0_lock;
        sel_we    = gnt[1] ? bus.m1_we    : bus.m0_we;
        sel_addr  = gnt[1] ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
        cnt_next  = (state_q == IDLE) ? CNT_W'(1) : lock_cnt_q + CNT_W'(1);
    end

    assign bus.m0_gnt    = gnt[0];
    assign bus.m1_gnt    = gnt[1];
    assign bus.ram_addr  = sel_addr;
    assign bus.ram_we    = (|gnt) & sel_we;
    assign bus.ram_wdata = sel_wdata;

    assign bus.m0_rdata  = bus.ram_rdata;
    assign bus.m1_rdata  = bus.ram_rdata;
    assign bus.m0_rvalid = ~reset & rpend_q & ~rtag_q & bus.ram_rdata_valid;
    assign bus.m1_rvalid = ~reset & rpend_q &  rtag_q & bus.ram_rdata_valid;

    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_cnt_q  <= '0;
            force_q     <= 1'b0;
            force_ptr_q <= 1'b0;
            rpend_q     <= 1'b0;
            rtag_q      <= 1'b0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            rpend_q <= (|gnt) & ~sel_we;
            rtag_q  <= gnt[1];
            force_q <= 1'b0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            if (state_q == IDLE && (|gnt)) begin
                rr_ptr_q <= gnt[0];
            end
`endif
            if (|gnt) begin
                if (sel_lock && (cnt_next < CNT_W'(MAX_LOCK))) begin
                    state_q    <= gnt[1] ? OWN1 : OWN0;
                    lock_cnt_q <= cnt_next;
                end else begin
                    state_q    <= IDLE;
                    lock_cnt_q <= '0;
                    // Lock budget exhausted: hand the next IDLE cycle to the other port.
                    if (sel_lock) begin
                        force_q     <= 1'b1;
                        force_ptr_q <= gnt[0];
                    end
                end
            end else if (state_q != IDLE) begin
                state_q    <= IDLE;
                lock_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (MAX_LOCK=4) with a one-cycle-latency RAM model.
// Contention expectations follow RAM_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_ram_arbiter;
    import dlx_mem_pkg::*;

    logic       clk;
    logic       reset;
    arb_state_e dbg_state;
    int         n_cmp;
    int         n_err;

    logic [31:0] mem [0:255];

    ram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ram_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_LOCK   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: writes land at the edge, reads return one cycle later
    always @(posedge clk) begin
        bus.ram_rdata_valid <= 1'b0;
        if (reset) begin
            bus.ram_rdata <= '0;
            mem[1] <= 32'h44;
            mem[2] <= 32'h88;
            mem[3] <= 32'hCC;
            mem[4] <= 32'hA;
            mem[8] <= 32'hB;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
        end else if (bus.m0_gnt | bus.m1_gnt) begin
            bus.ram_rdata_valid <= 1'b1;
            bus.ram_rdata       <= mem[bus.ram_addr[9:2]];
        end
    end

    function automatic mem_req_t rq(input logic lock, input logic we,
                                    input logic [31:0] a, input logic [31:0] d);
        mem_req_t r;
        r.req   = 1'b1;
        r.lock  = lock;
        r.we    = we;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    function automatic mem_req_t none();
        mem_req_t r;
        r = '0;
        return r;
    endfunction

    task automatic drive(input mem_req_t r0, input mem_req_t r1);
        bus.m0_req   = r0.req;
        bus.m0_lock  = r0.lock;
        bus.m0_we    = r0.we;
        bus.m0_addr  = r0.addr;
        bus.m0_wdata = r0.wdata;
        bus.m1_req   = r1.req;
        bus.m1_lock  = r1.lock;
        bus.m1_we    = r1.we;
        bus.m1_addr  = r1.addr;
        bus.m1_wdata = r1.wdata;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, settle, then the caller checks
    task automatic apply(input mem_req_t r0, input mem_req_t r1);
        drive(r0, r1);
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(none(), none());
        next_cycle();
        next_cycle();

        // Reset with a pending write request
        apply(rq(0, 1, 32'h40, 32'h1234), none());
        chk("rst_gnt0", 32'(bus.m0_gnt), 0);
        chk("rst_gnt1", 32'(bus.m1_gnt), 0);
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_rv0", 32'(bus.m0_rvalid), 0);
        chk("rst_rv1", 32'(bus.m1_rvalid), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        next_cycle();
        reset = 1'b0;
        apply(none(), none());
        next_cycle();

        // Contention: m0 @0x10 (0xA), m1 @0x20 (0xB)
        apply(rq(0, 0, 32'h10, 0), rq(0, 0, 32'h20, 0));
        chk("a1_gnt0", 32'(bus.m0_gnt), 1);
        chk("a1_gnt1", 32'(bus.m1_gnt), 0);
        chk("a1_addr", bus.ram_addr, 32'h10);
        next_cycle();
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        apply(rq(0, 0, 32'h10, 0), rq(0, 0, 32'h20, 0));
        chk("a2_gnt0", 32'(bus.m0_gnt), 0);
        chk("a2_gnt1", 32'(bus.m1_gnt), 1);
        chk("a2_rv0", 32'(bus.m0_rvalid), 1);
        chk("a2_rd0", bus.m0_rdata, 32'hA);
        next_cycle();
        apply(rq(0, 0, 32'h10, 0), none());
        chk("a3_gnt0", 32'(bus.m0_gnt), 1);
        chk("a3_rv1", 32'(bus.m1_rvalid), 1);
        chk("a3_rd1", bus.m1_rdata, 32'hB);
        chk("a3_rv0", 32'(bus.m0_rvalid), 0);
        next_cycle();
        apply(none(), none());
        chk("a4_rv0", 32'(bus.m0_rvalid), 1);
        chk("a4_rd0", bus.m0_rdata, 32'hA);
        chk("a4_rv1", 32'(bus.m1_rvalid), 0);
        next_cycle();
`else
        apply(rq(0, 0, 32'h10, 0), rq(0, 0, 32'h20, 0));
        chk("a2_gnt0", 32'(bus.m0_gnt), 1);
        chk("a2_gnt1", 32'(bus.m1_gnt), 0);
        chk("a2_rv0", 32'(bus.m0_rvalid), 1);
        chk("a2_rd0", bus.m0_rdata, 32'hA);
        next_cycle();
        apply(none(), rq(0, 0, 32'h20, 0));
        chk("a3_gnt1", 32'(bus.m1_gnt), 1);
        chk("a3_rv0", 32'(bus.m0_rvalid), 1);
        chk("a3_rd0", bus.m0_rdata, 32'hA);
        next_cycle();
        apply(none(), none());
        chk("a4_rv1", 32'(bus.m1_rvalid), 1);
        chk("a4_rd1", bus.m1_rdata, 32'hB);
        chk("a4_rv0", 32'(bus.m0_rvalid), 0);
        next_cycle();
`endif

        // Lock: m1 does three writes (lock,lock,unlock) while m0 waits
        apply(none(), rq(1, 1, 32'h100, 32'h1));
        chk("b0_gnt1", 32'(bus.m1_gnt), 1);
        chk("b0_we", 32'(bus.ram_we), 1);
        next_cycle();
        apply(rq(0, 0, 32'h4, 0), rq(1, 1, 32'h104, 32'h2));
        chk("b1_state", 32'(dbg_state), 32'(OWN1));
        chk("b1_gnt1", 32'(bus.m1_gnt), 1);
        chk("b1_gnt0", 32'(bus.m0_gnt), 0);
        next_cycle();
        apply(rq(0, 0, 32'h4, 0), rq(0, 1, 32'h108, 32'h3));
        chk("b2_gnt1", 32'(bus.m1_gnt), 1);
        chk("b2_gnt0", 32'(bus.m0_gnt), 0);
        next_cycle();
        apply(rq(0, 0, 32'h4, 0), none());
        chk("b3_state", 32'(dbg_state), 32'(IDLE));
        chk("b3_gnt0", 32'(bus.m0_gnt), 1);
        chk("b3_rv1", 32'(bus.m1_rvalid), 0);
        next_cycle();
        apply(none(), none());
        chk("b4_rv0", 32'(bus.m0_rvalid), 1);
        chk("b4_rd0", bus.m0_rdata, 32'h44);
        next_cycle();

        // Forced release after four locked grants to m0
        apply(rq(1, 1, 32'h200, 32'h5), none());
        chk("c0_gnt0", 32'(bus.m0_gnt), 1);
        next_cycle();
        for (int k = 2; k <= 4; k++) begin
            apply(rq(1, 1, 32'h200, 32'h5), rq(0, 0, 32'h8, 0));
            chk($sformatf("c%0d_state", k), 32'(dbg_state), 32'(OWN0));
            chk($sformatf("c%0d_gnt0", k), 32'(bus.m0_gnt), 1);
            chk($sformatf("c%0d_gnt1", k), 32'(bus.m1_gnt), 0);
            next_cycle();
        end
        apply(rq(1, 1, 32'h200, 32'h5), rq(0, 0, 32'h8, 0));
        chk("c5_state", 32'(dbg_state), 32'(IDLE));
        chk("c5_gnt1", 32'(bus.m1_gnt), 1);
        chk("c5_gnt0", 32'(bus.m0_gnt), 0);
        next_cycle();
        apply(rq(1, 1, 32'h200, 32'h5), none());
        chk("c6_rv1", 32'(bus.m1_rvalid), 1);
        chk("c6_rd1", bus.m1_rdata, 32'h88);
        chk("c6_gnt0", 32'(bus.m0_gnt), 1);
        next_cycle();
        apply(none(), none());
        chk("c7_state", 32'(dbg_state), 32'(OWN0));
        chk("c7_gnt0", 32'(bus.m0_gnt), 0);
        next_cycle();

        // Alternating reads with no bubble
        apply(rq(0, 0, 32'h4, 0), none());
        chk("d0_state", 32'(dbg_state), 32'(IDLE));
        chk("d0_gnt0", 32'(bus.m0_gnt), 1);
        chk("d0_addr", bus.ram_addr, 32'h4);
        next_cycle();
        apply(none(), rq(0, 0, 32'h8, 0));
        chk("d1_gnt1", 32'(bus.m1_gnt), 1);
        chk("d1_rv0", 32'(bus.m0_rvalid), 1);
        chk("d1_rd0", bus.m0_rdata, 32'h44);
        chk("d1_rv1", 32'(bus.m1_rvalid), 0);
        next_cycle();
        apply(rq(0, 0, 32'hC, 0), none());
        chk("d2_gnt0", 32'(bus.m0_gnt), 1);
        chk("d2_rv1", 32'(bus.m1_rvalid), 1);
        chk("d2_rd1", bus.m1_rdata, 32'h88);
        chk("d2_rv0", 32'(bus.m0_rvalid), 0);
        next_cycle();
        apply(none(), none());
        chk("d3_rv0", 32'(bus.m0_rvalid), 1);
        chk("d3_rd0", bus.m0_rdata, 32'hCC);
        chk("d3_rv1", 32'(bus.m1_rvalid), 0);
        next_cycle();

        // Write from m0, read back from m1
        apply(rq(0, 1, 32'h40, 32'hDEADBEEF), none());
        chk("e0_gnt0", 32'(bus.m0_gnt), 1);
        chk("e0_we", 32'(bus.ram_we), 1);
        chk("e0_wdata", bus.ram_wdata, 32'hDEADBEEF);
        next_cycle();
        apply(none(), rq(0, 0, 32'h40, 0));
        chk("e1_gnt1", 32'(bus.m1_gnt), 1);
        chk("e1_we", 32'(bus.ram_we), 0);
        chk("e1_rv0", 32'(bus.m0_rvalid), 0);
        next_cycle();
        apply(none(), none());
        chk("e2_rv1", 32'(bus.m1_rvalid), 1);
        chk("e2_rd1", bus.m1_rdata, 32'hDEADBEEF);
        next_cycle();
        apply(none(), none());
        chk("e3_rv1", 32'(bus.m1_rvalid), 0);
        next_cycle();

        // Reset in the middle of an m1 lock with a read in flight
        apply(none(), rq(1, 0, 32'h20, 0));
        chk("f0_gnt1", 32'(bus.m1_gnt), 1);
        next_cycle();
        reset = 1'b1;
        apply(rq(0, 1, 32'h40, 32'h77), rq(1, 0, 32'h20, 0));
        chk("f1_gnt0", 32'(bus.m0_gnt), 0);
        chk("f1_gnt1", 32'(bus.m1_gnt), 0);
        chk("f1_rv1", 32'(bus.m1_rvalid), 0);
        chk("f1_we", 32'(bus.ram_we), 0);
        next_cycle();
        apply(rq(0, 1, 32'h40, 32'h77), rq(1, 0, 32'h20, 0));
        chk("f2_state", 32'(dbg_state), 32'(IDLE));
        chk("f2_gnt1", 32'(bus.m1_gnt), 0);
        chk("f2_we", 32'(bus.ram_we), 0);
        chk("f2_rv1", 32'(bus.m1_rvalid), 0);
        next_cycle();
        reset = 1'b0;
        apply(rq(0, 0, 32'h10, 0), none());
        chk("f3_state", 32'(dbg_state), 32'(IDLE));
        chk("f3_gnt0", 32'(bus.m0_gnt), 1);
        chk("f3_rv0", 32'(bus.m0_rvalid), 0);
        chk("f3_rv1", 32'(bus.m1_rvalid), 0);
        next_cycle();
        apply(none(), none());
        chk("f4_rv0", 32'(bus.m0_rvalid), 1);
        chk("f4_rd0", bus.m0_rdata, 32'hA);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of both ports and the RAM port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter MAX_LOCK, default 8, maximum consecutive grants to one locked owner.
REQ-004 SHALL have one clock and a synchronous active-high reset:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
REQ-005 SHALL have the following requester ports, for i = 0 (DLX data port) and i = 1 (second master):
- m<i>_req  in  1  access request
- m<i>_lock  in  1  keep ownership after this grant
- m<i>_we  in  1  write enable
- m<i>_addr  in  ADDR_WIDTH  address
- m<i>_wdata  in  DATA_WIDTH  write data
- m<i>_gnt  out  1  request issued this cycle
- m<i>_rdata  out  DATA_WIDTH  read data
- m<i>_rvalid  out  1  read data valid
REQ-006 SHALL have the following RAM ports:
- ram_addr  out  ADDR_WIDTH  address
- ram_we  out  1  write enable
- ram_wdata  out  DATA_WIDTH  write data
- ram_rdata  in  DATA_WIDTH  read data
- ram_rdata_valid  in  1  read data valid, one cycle after a read

Function
REQ-007 SHALL issue at most one RAM access per cycle, to exactly one requester, with its m<i>_gnt high in that same cycle.
REQ-008 SHALL drive ram_addr, ram_we and ram_wdata combinationally from the granted requester; ram_we SHALL be 0 when there is no grant.
REQ-009 Requester rule: m<i>_req, m<i>_we, m<i>_addr and m<i>_wdata SHALL be held stable until m<i>_gnt is seen; dropping req before the grant is allowed.
REQ-010 SHALL implement the state machine IDLE, OWN0, OWN1:
- IDLE: arbitrate.
- A grant with m<i>_lock=1 goes to OWN<i>.
- OWN<i>: only port i is granted; the other port waits.
- OWN<i> returns to IDLE when port i is granted with lock=0, when port i drops req, or when the lock counter reaches MAX_LOCK.
REQ-011 SHALL count consecutive grants in OWN<i>; when the count reaches MAX_LOCK, the next cycle is IDLE and the other port, if requesting, wins (forced release).
REQ-012 SHALL record the owner of each read in a one-bit tag register and route ram_rdata_valid/ram_rdata to that port one cycle after the grant; the other port's rvalid SHALL be 0.
REQ-013 m<i>_rdata MAY carry ram_rdata unconditionally; m<i>_rvalid SHALL never assert for writes.
REQ-014 Back-to-back reads from alternating ports SHALL each return data to the correct port with no bubble.
REQ-015 With both ports requesting simultaneously in IDLE, the winner SHALL follow REQ-020/021.

Reset
REQ-016 On reset: state IDLE, lock counter 0, round-robin pointer to port 0, read tag cleared, and all m<i>_gnt and m<i>_rvalid = 0 in the cycle after reset is sampled.
REQ-017 Reset mid-lock SHALL abandon ownership; a read granted in the cycle before reset SHALL NOT produce rvalid after reset.
REQ-018 ram_we SHALL be 0 while reset is high.

Configuration
REQ-019 SHALL use macro RAM_ARBITER_ROUND_ROBIN_EN.
REQ-020 With the macro defined: round-robin; on contention in IDLE, the port not granted last wins, and the pointer updates on every IDLE grant.
REQ-021 Without the macro: fixed priority, port 0 (DLX) always wins contention in IDLE; the pointer logic is absent.

Structure
REQ-022 SHALL place the following in package dlx_mem_pkg: the state enum type (IDLE, OWN0, OWN1), a packed request struct (req, lock, we, addr, wdata), and the default width constants.
REQ-023 SHALL place the winner selection in a sub-module arb_pick2 (inputs req[1:0], pointer; output one-hot grant).

Verification
REQ-024 Reset: assert reset for 2 cycles during traffic -> all gnt/rvalid 0, ram_we 0, state IDLE.
REQ-025 Contention: both ports read in the same cycle, addr 0x10 and 0x20, RAM holding 0xA and 0xB:
- Round-robin build: m0 is granted, then m1; m0_rvalid carries 0xA, then m1_rvalid carries 0xB.
- Fixed-priority build: m0 wins every contention.
REQ-026 Lock: m1 holds lock with 3 writes while m0 requests -> m0 gets no grant until the cycle after m1's unlocked grant.
REQ-027 Forced release: MAX_LOCK=4, m0 locks continuously while m1 requests -> m1 is granted exactly after m0's 4th grant.
REQ-028 Alternating reads m0@0x4, m1@0x8, m0@0xC on consecutive cycles -> each rvalid arrives one cycle after its grant, on the correct port with the correct data.
REQ-029 Write then read: m0 writes 0xDEADBEEF to 0x40, then m1 reads 0x40 -> m1_rdata is 0xDEADBEEF and m1_rvalid pulses once.
